carry_ripple_operand_sequencer: RTL and testbench
=================================================

// Module: carry_ripple_operand_sequencer
// PURPOSE
//   Upstream driver and result checker for the 7-bit carry-ripple adder macro.
//   - Accepts operands A, B and carry-in over a valid/ready stream and drives them to the adder.
//   - Waits a programmable settle time for the ripple chain, then captures {cout,sum}.
//   - Compares the captured value against a digital golden sum.
//   - Presents the result downstream and keeps a saturating mismatch count.
// PARAMETERS
//   WIDTH          7   operand width, matching the adder
//   SETTLE_CYCLES  4   clock cycles between B acceptance and result capture (>=1)
//   ERR_CNT_W      8   width of the saturating mismatch counter
// PORTS
//   clk        in   1          single clock; all state changes on its rising edge
//   rst        in   1          reset: synchronous, active-high
//   in_valid   in   1          operand beat valid
//   in_ready   out  1          sequencer can accept an operand beat
//   in_data    in   WIDTH      operand: first accepted beat = A, second = B
//   in_cin     in   1          carry-in, sampled only with the B beat
//   add_a      out  WIDTH      operand A to the adder, registered
//   add_b      out  WIDTH      operand B to the adder, registered
//   add_cin    out  1          carry-in to the adder, registered
//   add_sum    in   WIDTH      adder sum, sampled only at the capture edge
//   add_cout   in   1          adder carry-out, sampled only at the capture edge
//   res_valid  out  1          result available
//   res_ready  in   1          downstream accepts the result
//   res_sum    out  WIDTH+1    captured {add_cout, add_sum}
//   res_ok     out  1          1 = captured value equals the golden sum
//   err_count  out  ERR_CNT_W  count of mismatches, saturating at all-ones
//   busy       out  1          high in any state other than LOAD_A
// BEHAVIOUR
//   Reset (rst=1 at an edge): the following are all 0 after the edge:
//     - add_a, add_b, add_cin, res_sum, res_ok, res_valid, err_count
//     - settle counter; state goes to LOAD_A.
//   Reset takes priority over every other event.
//   While rst=1: in_ready=0.
//   Reset mid-operation aborts the operation:
//     - no res_valid is produced;
//     - the partial operands are discarded.
//   Handshakes: a transfer occurs at an edge where valid and ready are both 1.
//     - ready depends only on state, never on valid.
//   FSM:
//     LOAD_A : in_ready=1. On transfer: add_a<=in_data, go to LOAD_B.
//     LOAD_B : in_ready=1. On transfer: add_b<=in_data, add_cin<=in_cin,
//              counter<=SETTLE_CYCLES-1, go to SETTLE.
//     SETTLE : in_ready=0.
//              - counter!=0: counter decrements each edge.
//              - counter==0: at that edge capture res_sum<={add_cout,add_sum},
//                res_ok<=(res_sum==golden), res_valid<=1, go to OUT.
//     OUT    : in_ready=0. res_valid, res_sum and res_ok stay stable until a
//              transfer on res_valid & res_ready. Then res_valid<=0, go to LOAD_A.
//   Latency: when B is accepted at edge n, res_valid is first high after edge
//     n+SETTLE_CYCLES.
//   Golden sum: {1'b0,add_a} + {1'b0,add_b} + add_cin, computed in WIDTH+1 bits.
//     - No overflow is possible: 0x7F+0x7F+1 = 0xFF.
//   err_count: increments at the capture edge when res_ok will be 0.
//     - At all-ones it holds (no wrap).
//   add_a, add_b and add_cin hold their values between operations.
//     - A beat updates only add_a; add_b and add_cin keep old values until the B beat.
//   There is no back-to-back overlap: the next A is not accepted before the
//     res_valid & res_ready transfer.
// TESTING
//   - Ideal adder model, A=0x7F, B=0x01, cin=0 -> res_sum=0x080, res_ok=1,
//     err_count=0.
//   - Ideal model, A=0x7F, B=0x7F, cin=1 -> res_sum=0x0FF, res_ok=1;
//     B accepted at edge n -> res_valid high after edge n+4 and not before.
//   - Faulty model with sum bit 3 stuck at 0, A=0x08, B=0x00 -> res_sum=0x000,
//     res_ok=0, err_count=1.
//   - res_ready held 0 for 10 cycles in OUT -> res_valid, res_sum and res_ok stay
//     stable, and in_ready=0. On release: LOAD_A, in_ready=1.
//   - ERR_CNT_W=2, five mismatching operations -> err_count reads 1,2,3,3,3.
//   - rst=1 for one cycle during SETTLE -> no res_valid, all outputs 0, state LOAD_A.
//     The next A/B pair completes normally.

Source files
------------

// File: rtl/carry_ripple_operand_sequencer_if.sv
// Operand/result bundle between the ripple-adder sequencer and its neighbours.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on operands, res_valid/res_ready on results.
interface carry_ripple_operand_sequencer_if #(
  parameter int WIDTH     = 7,
  parameter int ERR_CNT_W = 8
) ();
  // operand stream
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_cin;
  // adder macro connection
  logic [WIDTH-1:0]     add_a;
  logic [WIDTH-1:0]     add_b;
  logic                 add_cin;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  // result stream and status
  logic                 res_valid;
  logic                 res_ready;
  logic [WIDTH:0]       res_sum;
  logic                 res_ok;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 busy;

  // sequencer side
  modport master (
    input  in_valid, in_data, in_cin, add_sum, add_cout, res_ready,
    output in_ready, add_a, add_b, add_cin, res_valid, res_sum, res_ok,
           err_count, busy
  );

  // environment side: operand source, adder macro, result sink
  modport slave (
    output in_valid, in_data, in_cin, add_sum, add_cout, res_ready,
    input  in_ready, add_a, add_b, add_cin, res_valid, res_sum, res_ok,
           err_count, busy
  );
endinterface

// File: rtl/carry_ripple_operand_sequencer.sv
// Feeds A/B/cin to the ripple adder, waits for the chain to settle, checks against golden.
// Latency: result valid SETTLE_CYCLES edges after the B beat is accepted.
// Backpressure: result held until res_ready; no new A accepted until the result drains.
module carry_ripple_operand_sequencer #(
  parameter int WIDTH         = 7,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  carry_ripple_operand_sequencer_if.master bus
);

  // SETTLE_CYCLES-1 must fit; keep at least one bit when SETTLE_CYCLES is 1
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SETTLE = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_in_ready;
  logic                 r_busy;
  logic [WIDTH-1:0]     r_add_a;
  logic [WIDTH-1:0]     r_add_b;
  logic                 r_add_cin;
  logic                 r_res_valid;
  logic [WIDTH:0]       r_res_sum;
  logic                 r_res_ok;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_in_fire;
  logic                 w_res_fire;
  logic [WIDTH:0]       w_golden;
  logic [WIDTH:0]       w_capture;
  logic                 w_match;

  // ready is a pure function of state, forced low while reset is asserted
  assign bus.in_ready  = r_in_ready & ~rst;
  assign w_in_fire     = bus.in_valid & bus.in_ready;
  assign w_res_fire    = r_res_valid & bus.res_ready;

  // WIDTH+1 bits is enough: all-ones + all-ones + 1 still fits
  assign w_golden  = {1'b0, r_add_a} + {1'b0, r_add_b} + {{WIDTH{1'b0}}, r_add_cin};
  assign w_capture = {bus.add_cout, bus.add_sum};
  assign w_match   = (w_capture == w_golden);

  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.add_cin   = r_add_cin;
  assign bus.res_valid = r_res_valid;
  assign bus.res_sum   = r_res_sum;
  assign bus.res_ok    = r_res_ok;
  assign bus.err_count = r_err_count;
  assign bus.busy      = r_busy;

  // sequencing FSM with registered ready/busy/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD_A;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_cin   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_ok    <= 1'b0;
      r_err_count <= '0;
    end else begin
      unique case (r_state)
        LOAD_A: begin
          // A beat only touches add_a; B/cin keep the previous operation's values
          if (w_in_fire) begin
            r_add_a <= bus.in_data;
            r_busy  <= 1'b1;
            r_state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (w_in_fire) begin
            r_add_b    <= bus.in_data;
            r_add_cin  <= bus.in_cin;
            r_cnt      <= CNT_W'(SETTLE_CYCLES - 1);
            r_in_ready <= 1'b0;
            r_state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            // adder outputs are only trusted at this edge
            r_res_sum   <= w_capture;
            r_res_ok    <= w_match;
            r_res_valid <= 1'b1;
            if (!w_match && (r_err_count != {ERR_CNT_W{1'b1}})) begin
              r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
            r_state <= OUT;
          end
        end
        OUT: begin
          if (w_res_fire) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= LOAD_A;
          end
        end
        default: begin
          r_state <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carry_ripple_operand_sequencer.sv
// Bench for the ripple-adder sequencer: two instances (8-bit and 2-bit error counters).
// Both share the operand/result stream; each has its own adder model with stuck-at-0 mask.
// A transaction-level model predicts every output on every cycle.
module tb_carry_ripple_operand_sequencer;

  localparam int SC = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [6:0] in_data;
  logic       in_cin;
  logic       res_ready;
  logic [6:0] mask0;
  logic [6:0] mask1;
  logic [7:0] s0;
  logic [7:0] s1;

  int checks   = 0;
  int failures = 0;

  carry_ripple_operand_sequencer_if #(.WIDTH(7), .ERR_CNT_W(8)) bus0 ();
  carry_ripple_operand_sequencer_if #(.WIDTH(7), .ERR_CNT_W(2)) bus1 ();

  carry_ripple_operand_sequencer #(.WIDTH(7), .SETTLE_CYCLES(SC), .ERR_CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  carry_ripple_operand_sequencer #(.WIDTH(7), .SETTLE_CYCLES(SC), .ERR_CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.in_cin    = in_cin;
  assign bus0.res_ready = res_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.in_cin    = in_cin;
  assign bus1.res_ready = res_ready;

  // adder macros: ideal sum with optional stuck-at-0 sum bits
  assign s0 = {1'b0, bus0.add_a} + {1'b0, bus0.add_b} + {7'd0, bus0.add_cin};
  assign s1 = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {7'd0, bus1.add_cin};
  assign bus0.add_sum  = s0[6:0] & ~mask0;
  assign bus0.add_cout = s0[7];
  assign bus1.add_sum  = s1[6:0] & ~mask1;
  assign bus1.add_cout = s1[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int         beats;        // operand beats taken in the current operation
  int         since_b;      // edges elapsed since the B beat
  logic       m_valid;
  logic [6:0] m_a, m_b;
  logic       m_cin;
  logic [7:0] m_sum [2];
  logic       m_ok  [2];
  int         m_err [2];
  int         err_max [2];
  logic       m_started = 1'b0;

  function automatic logic [7:0] faulty(input logic [7:0] ideal, input logic [6:0] m);
    return {ideal[7], ideal[6:0] & ~m};
  endfunction

  always @(posedge clk) begin
    int         g;
    logic [7:0] gv;
    logic [7:0] got;
    logic [6:0] mk;
    err_max[0] = 255;
    err_max[1] = 3;
    if (rst) begin
      beats = 0; since_b = 0; m_valid = 1'b0;
      m_a = '0; m_b = '0; m_cin = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_sum[i] = '0; m_ok[i] = 1'b0; m_err[i] = 0;
      end
    end else if (beats < 2) begin
      if (in_valid) begin
        if (beats == 0) m_a = in_data;
        else begin
          m_b = in_data; m_cin = in_cin; since_b = 0;
        end
        beats++;
      end
    end else if (!m_valid) begin
      since_b++;
      if (since_b == SC) begin
        g  = int'(m_a) + int'(m_b) + int'(m_cin);
        gv = 8'(g);
        for (int i = 0; i < 2; i++) begin
          mk  = (i == 0) ? mask0 : mask1;
          got = faulty(gv, mk);
          m_sum[i] = got;
          m_ok[i]  = (got == gv);
          if (!m_ok[i] && m_err[i] < err_max[i]) m_err[i]++;
        end
        m_valid = 1'b1;
      end
    end else if (res_ready) begin
      m_valid = 1'b0;
      beats   = 0;
    end
    m_started = 1'b1;
  end

  // compare every output of both instances against the model, away from the edge
  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready0",  32'(bus0.in_ready),  32'(!rst && beats < 2));
      chk("in_ready1",  32'(bus1.in_ready),  32'(!rst && beats < 2));
      chk("busy0",      32'(bus0.busy),      32'(beats != 0));
      chk("busy1",      32'(bus1.busy),      32'(beats != 0));
      chk("res_valid0", 32'(bus0.res_valid), 32'(m_valid));
      chk("res_valid1", 32'(bus1.res_valid), 32'(m_valid));
      chk("add_a",      32'(bus0.add_a),     32'(m_a));
      chk("add_b",      32'(bus0.add_b),     32'(m_b));
      chk("add_cin",    32'(bus0.add_cin),   32'(m_cin));
      chk("res_sum0",   32'(bus0.res_sum),   32'(m_sum[0]));
      chk("res_sum1",   32'(bus1.res_sum),   32'(m_sum[1]));
      chk("res_ok0",    32'(bus0.res_ok),    32'(m_ok[0]));
      chk("res_ok1",    32'(bus1.res_ok),    32'(m_ok[1]));
      chk("err_count0", 32'(bus0.err_count), 32'(m_err[0]));
      chk("err_count1", 32'(bus1.err_count), 32'(m_err[1]));
    end
  end

  // ---------------- directed drivers ----------------
  task automatic send_beat(input logic [6:0] d, input logic c);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_cin = c;
    @(negedge clk);
    while (!bus0.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_beat: in_ready never rose within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus0.res_valid) break;
    end
    if (!bus0.res_valid) begin
      checks++; failures++;
      $display("FAIL wait_result: res_valid absent after %0d cycles", lat);
    end
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         lat;
    logic [6:0] a;
    int         exp_err [5];
    exp_err = '{1, 2, 3, 3, 3};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_cin = 1'b0;
    res_ready = 1'b0; mask0 = '0; mask1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(bus0.res_valid), 32'd0);
    chk("rst_add_a",     32'(bus0.add_a),     32'd0);
    chk("rst_res_sum",   32'(bus0.res_sum),   32'd0);
    chk("rst_err",       32'(bus0.err_count), 32'd0);
    chk("rst_in_ready",  32'(bus0.in_ready),  32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(bus0.in_ready), 32'd1);

    // 0x7F + 0x01 carries into bit 7
    send_beat(7'h7F, 1'b0);
    send_beat(7'h01, 1'b0);
    wait_result(lat);
    chk("t1_sum", 32'(bus0.res_sum),   32'h80);
    chk("t1_ok",  32'(bus0.res_ok),    32'd1);
    chk("t1_err", 32'(bus0.err_count), 32'd0);
    take_result();

    // largest sum, latency, and a 10-cycle downstream stall
    send_beat(7'h7F, 1'b0);
    send_beat(7'h7F, 1'b1);
    wait_result(lat);
    chk("t2_latency", 32'(lat), 32'd4);
    chk("t2_sum", 32'(bus0.res_sum), 32'hFF);
    chk("t2_ok",  32'(bus0.res_ok),  32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_valid",    32'(bus0.res_valid), 32'd1);
      chk("stall_sum",      32'(bus0.res_sum),   32'hFF);
      chk("stall_ok",       32'(bus0.res_ok),    32'd1);
      chk("stall_in_ready", 32'(bus0.in_ready),  32'd0);
    end
    take_result();
    chk("release_in_ready", 32'(bus0.in_ready),  32'd1);
    chk("release_busy",     32'(bus0.busy),      32'd0);
    chk("release_valid",    32'(bus0.res_valid), 32'd0);

    // sum bit 3 stuck at 0
    mask0 = 7'h08;
    send_beat(7'h08, 1'b0);
    send_beat(7'h00, 1'b0);
    wait_result(lat);
    chk("t3_sum", 32'(bus0.res_sum),   32'h00);
    chk("t3_ok",  32'(bus0.res_ok),    32'd0);
    chk("t3_err", 32'(bus0.err_count), 32'd1);
    take_result();
    mask0 = '0;

    // reset pulse while the ripple chain is settling
    send_beat(7'h11, 1'b0);
    send_beat(7'h22, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(bus0.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", 32'(bus0.res_valid), 32'd0);
    chk("abort_add_a", 32'(bus0.add_a),     32'd0);
    chk("abort_add_b", 32'(bus0.add_b),     32'd0);
    chk("abort_cin",   32'(bus0.add_cin),   32'd0);
    chk("abort_err",   32'(bus0.err_count), 32'd0);
    chk("abort_busy",  32'(bus0.busy),      32'd0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(bus0.res_valid), 32'd0);
    end
    send_beat(7'h10, 1'b0);
    send_beat(7'h20, 1'b1);
    wait_result(lat);
    chk("post_rst_sum", 32'(bus0.res_sum), 32'h31);
    chk("post_rst_ok",  32'(bus0.res_ok),  32'd1);
    take_result();

    // 2-bit counter saturates after three mismatches
    mask1 = 7'h08;
    for (int k = 0; k < 5; k++) begin
      a = 7'($urandom) | 7'h08;
      send_beat(a, 1'b0);
      send_beat(7'h00, 1'b0);
      wait_result(lat);
      chk("sat_ok",  32'(bus1.res_ok),    32'd0);
      chk("sat_err", 32'(bus1.err_count), 32'(exp_err[k]));
      take_result();
    end
    mask1 = '0;

    // free-running random traffic, faults and resets; model checks every cycle
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 7'($urandom);
      in_cin    = 1'($urandom);
      res_ready = 1'($urandom);
      rst       = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) begin
        mask0 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
        mask1 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
